// File: rtl/lc3_mem_pkg.sv
// ----------------------------------------------------------------------------
// lc3_mem_pkg
// Shared definitions for the LC-3 memory controller:
//   - state_t   : access sequencer states
//   - CNT_W     : width of the wait-state counter (0..15 wait cycles)
//   - *_ADDR    : memory-mapped keyboard/display register addresses, used
//                 only when the design is built with LC3_MMIO_EN defined
// ----------------------------------------------------------------------------
package lc3_mem_pkg;

    // ST_ACCESS is the cycle right after a request is accepted; ST_WAIT holds
    // the extra wait states and is bypassed entirely when WAIT_CYCLES is 0.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int CNT_W = 4;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

endpackage

// File: rtl/lc3_mmio_regs.sv
// ----------------------------------------------------------------------------
// lc3_mmio_regs
// Keyboard/display device registers of the LC-3 (KBSR, KBDR, DSR, DDR).
// Only instantiated by lc3_mem_ctrl when LC3_MMIO_EN is defined.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   commit             1 on the edge that completes the current access
//   acc_rw/addr/wdata  latched access (1 = write)
//   kbd_valid/kbd_data keyboard strobe and character
//   dsp_ready          display can accept a character
//   hit                access address is one of the device registers
//   rdata              read value of the addressed register (combinational)
//   kbd_ack            one-cycle pulse, aligned with r, after a KBDR read
//   dsp_data/dsp_valid character written to DDR, valid for one cycle with r
// ----------------------------------------------------------------------------
module lc3_mmio_regs
    import lc3_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        commit,
    input  logic        acc_rw,
    input  logic [15:0] acc_addr,
    input  logic [15:0] acc_wdata,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    input  logic        dsp_ready,
    output logic        hit,
    output logic [15:0] rdata,
    output logic        kbd_ack,
    output logic [7:0]  dsp_data,
    output logic        dsp_valid
);

    logic       kbsr_ready;
    logic [7:0] kbd_key;
    logic       kbdr_read;
    logic       ddr_write;
    logic       unused_wdata_hi;

    assign unused_wdata_hi = ^acc_wdata[15:8];

    assign kbdr_read = commit && !acc_rw && (acc_addr == KBDR_ADDR);
    assign ddr_write = commit &&  acc_rw && (acc_addr == DDR_ADDR);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the case leaves it unassigned, which would infer a latch.
        hit   = 1'b1;
        rdata = '0;
        unique case (acc_addr)
            KBSR_ADDR: rdata = {kbsr_ready, 15'b0};
            KBDR_ADDR: rdata = {8'h00, kbd_key};
            DSR_ADDR:  rdata = {dsp_ready, 15'b0};
            DDR_ADDR:  rdata = '0;
            default:   hit   = 1'b0;
        endcase
    end

    // The KBDR read clears the ready flag before a same-cycle keystroke is
    // considered, so that keystroke is latched rather than dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kbsr_ready <= 1'b0;
            kbd_key    <= '0;
            kbd_ack    <= 1'b0;
            dsp_data   <= '0;
            dsp_valid  <= 1'b0;
        end else begin
            kbd_ack   <= kbdr_read;
            dsp_valid <= ddr_write;
            if (ddr_write) begin
                dsp_data <= acc_wdata[7:0];
            end
            if (kbd_valid && (!kbsr_ready || kbdr_read)) begin
                kbd_key    <= kbd_data;
                kbsr_ready <= 1'b1;
            end else if (kbdr_read) begin
                kbsr_ready <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// ----------------------------------------------------------------------------
// lc3_mem_ctrl
// LC-3 word-addressed memory with a request/ready handshake and a fixed
// number of wait states. A request sampled at edge k completes at edge
// k+WAIT_CYCLES+1, where r pulses for one cycle.
//
// Build option: define LC3_MMIO_EN to map the keyboard/display registers at
// xFE00..xFE06 (needs ADDR_W=16, DATA_W=16). Without it every address is
// plain memory and kbd_ack/dsp_valid/dsp_data stay 0.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   mio_en, rw, addr,       request; rw=1 write; rw/addr/data_in are
//   data_in                 captured with mio_en in IDLE
//   data_out                read data, held until the next read completes
//   r                       one-cycle completion pulse
//   kbd_valid, kbd_data,    keyboard input strobe/character, key-read ack
//   kbd_ack
//   dsp_ready, dsp_data,    display status, output character and strobe
//   dsp_valid
// ----------------------------------------------------------------------------
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mio_en,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              r,
    input  logic              kbd_valid,
    input  logic [7:0]        kbd_data,
    output logic              kbd_ack,
    input  logic              dsp_ready,
    output logic [7:0]        dsp_data,
    output logic              dsp_valid
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              lat_rw;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              commit;
    logic              mmio_hit;
    logic [DATA_W-1:0] mmio_rdata;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Completion edge: the last latched-access cycle with no wait left.
    // Derived from the async-reset state, so reset blocks a pending write.
    assign commit = ((state == ST_ACCESS) || (state == ST_WAIT)) && (cnt == '0);

`ifdef LC3_MMIO_EN
    lc3_mmio_regs u_mmio (
        .clk       (clk),
        .rst_n     (rst_n),
        .commit    (commit),
        .acc_rw    (lat_rw),
        .acc_addr  (lat_addr),
        .acc_wdata (lat_wdata),
        .kbd_valid (kbd_valid),
        .kbd_data  (kbd_data),
        .dsp_ready (dsp_ready),
        .hit       (mmio_hit),
        .rdata     (mmio_rdata),
        .kbd_ack   (kbd_ack),
        .dsp_data  (dsp_data),
        .dsp_valid (dsp_valid)
    );
`else
    logic unused_kbd_dsp;

    assign unused_kbd_dsp = ^{kbd_valid, kbd_data, dsp_ready};
    assign mmio_hit       = 1'b0;
    assign mmio_rdata     = '0;
    assign kbd_ack        = 1'b0;
    assign dsp_data       = '0;
    assign dsp_valid      = 1'b0;
`endif

    // NOTE: the storage array has its own clock-only block; memories are
    // never reset, which keeps them mappable onto RAM macros.
    always_ff @(posedge clk) begin
        if (commit && lat_rw && !mmio_hit) begin
            mem[lat_addr] <= lat_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            r         <= 1'b0;
            data_out  <= '0;
            lat_rw    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            r <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (mio_en) begin
                        lat_rw    <= rw;
                        lat_addr  <= addr;
                        lat_wdata <= data_in;
                        cnt       <= WAIT_LOAD;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS, ST_WAIT: begin
                    if (commit) begin
                        r     <= 1'b1;
                        state <= ST_DONE;
                        if (!lat_rw) begin
                            data_out <= mmio_hit ? mmio_rdata : mem[lat_addr];
                        end
                    end else begin
                        cnt   <= cnt - 1'b1;
                        state <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_lc3_mem_ctrl
// Three controllers (WAIT_CYCLES = 0, 3, 5) share clock, reset and the
// keyboard/display inputs. A table of directed accesses, hand-written
// multi-cycle sequences (back-to-back bubble, reset mid-write, device
// registers) and random accesses are checked against a reference model:
// an associative array of written words plus latency = WAIT_CYCLES+1.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lc3_mem_ctrl;

    localparam int ND = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mio_en   [ND];
    logic        rw       [ND];
    logic [15:0] addr     [ND];
    logic [15:0] data_in  [ND];
    logic [15:0] data_out [ND];
    logic        r        [ND];
    logic        kbd_ack  [ND];
    logic [7:0]  dsp_data [ND];
    logic        dsp_valid[ND];
    logic        kbd_valid;
    logic [7:0]  kbd_data;
    logic        dsp_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] ref_mem [int];
    logic [15:0] last_rd [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        lc3_mem_ctrl #(
            .ADDR_W      (16),
            .DATA_W      (16),
            .WAIT_CYCLES (g == 0 ? 0 : (g == 1 ? 3 : 5))
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .mio_en    (mio_en[g]),
            .rw        (rw[g]),
            .addr      (addr[g]),
            .data_in   (data_in[g]),
            .data_out  (data_out[g]),
            .r         (r[g]),
            .kbd_valid (kbd_valid),
            .kbd_data  (kbd_data),
            .kbd_ack   (kbd_ack[g]),
            .dsp_ready (dsp_ready),
            .dsp_data  (dsp_data[g]),
            .dsp_valid (dsp_valid[g])
        );
    end

    function automatic int wc(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 5);
    endfunction

    function automatic int key(input int d, input logic [15:0] a);
        return d * 65536 + int'({16'h0000, a});
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // One access on controller d. After the request edge the inputs are
    // scrambled (addr forced to alt) to show they are ignored.
    task automatic do_access(input int d, input bit wr, input logic [15:0] a,
                             input logic [15:0] wd, input logic [15:0] alt,
                             output logic [15:0] rd, output bit ack,
                             output bit dv, output logic [7:0] dd);
        int lat;
        mio_en[d]  = 1'b1;
        rw[d]      = wr;
        addr[d]    = a;
        data_in[d] = wd;
        @(posedge clk);
        #1;
        mio_en[d]  = 1'b0;
        rw[d]      = 1'($urandom);
        addr[d]    = alt;
        data_in[d] = 16'($urandom);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (r[d]) begin
                lat = n;
                break;
            end
        end
        rd  = data_out[d];
        ack = kbd_ack[d];
        dv  = dsp_valid[d];
        dd  = dsp_data[d];
        check($sformatf("latency_d%0d", d), lat, wc(d) + 1);
        if (lat > 0) begin
            @(posedge clk);
            #1;
            check("r_one_cycle", r[d], 1'b0);
            check("data_out_held_after_r", data_out[d], rd);
            check("strobes_one_cycle", {kbd_ack[d], dsp_valid[d]}, 2'b00);
        end
    endtask

    // Access plus model update: reads compare against exp, writes must
    // leave data_out at the last read value.
    task automatic run(input int d, input bit wr, input logic [15:0] a,
                       input logic [15:0] wd, input logic [15:0] exp,
                       output bit ack, output bit dv, output logic [7:0] dd);
        logic [15:0] rd;
        do_access(d, wr, a, wd, 16'($urandom), rd, ack, dv, dd);
        if (wr) begin
            check($sformatf("write_keeps_data_out_%h", a), rd, last_rd[d]);
        end else begin
            check($sformatf("read_%h_d%0d", a, d), rd, exp);
            last_rd[d] = exp;
        end
    endtask

    task automatic mem_op(input int d, input bit wr, input logic [15:0] a, input logic [15:0] wd);
        bit ack, dv;
        logic [7:0] dd;
        logic [15:0] exp;
        exp = 16'h0;
        if (wr) ref_mem[key(d, a)] = wd;
        else    exp = ref_mem[key(d, a)];
        run(d, wr, a, wd, exp, ack, dv, dd);
        check("no_dev_strobe_on_mem", {ack, dv}, 2'b00);
    endtask

    typedef struct {
        bit          wr;
        logic [15:0] a;
        logic [15:0] wd;
        logic [15:0] exp;
    } vec_t;

    initial begin
        vec_t        vt [8];
        logic [15:0] pool [6];
        logic [15:0] rd;
        bit          ack, dv;
        logic [7:0]  dd;
        int          r_seen;

        vt[0] = '{1'b1, 16'h3000, 16'h1234, 16'h0000};
        vt[1] = '{1'b0, 16'h3000, 16'h0000, 16'h1234};
        vt[2] = '{1'b1, 16'h0000, 16'h0F0F, 16'h0000};
        vt[3] = '{1'b1, 16'hFFFF, 16'hBEEF, 16'h0000};
        vt[4] = '{1'b0, 16'hFFFF, 16'h0000, 16'hBEEF};
        vt[5] = '{1'b0, 16'h0000, 16'h0000, 16'h0F0F};
        vt[6] = '{1'b0, 16'h3000, 16'h0000, 16'h1234};
        vt[7] = '{1'b1, 16'h3001, 16'h7777, 16'h0000};

        rst_n     = 1'b0;
        kbd_valid = 1'b0;
        kbd_data  = 8'h00;
        dsp_ready = 1'b0;
        for (int d = 0; d < ND; d++) begin
            mio_en[d]  = 1'b0;
            rw[d]      = 1'b0;
            addr[d]    = 16'h0;
            data_in[d] = 16'h0;
            last_rd[d] = 16'h0;
        end
        #1;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("reset_outputs_d%0d", d),
                  {data_out[d], r[d], kbd_ack[d], dsp_data[d], dsp_valid[d]}, 27'h0);
        end

        // Release at a falling edge; the first access must be taken at the
        // very next rising edge (its latency check covers that).
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed table on the zero-wait controller.
        for (int i = 0; i < 8; i++) begin
            if (vt[i].wr) ref_mem[key(0, vt[i].a)] = vt[i].wd;
            run(0, vt[i].wr, vt[i].a, vt[i].wd, vt[i].exp, ack, dv, dd);
        end

        // Held request: accepted every WAIT+3 edges (one-cycle bubble).
        mio_en[0] = 1'b1;
        rw[0]     = 1'b0;
        addr[0]   = 16'h3000;
        for (int n = 1; n <= 7; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("bubble_r_edge%0d", n), r[0], ((n - 1) % 3) == 1);
        end
        mio_en[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("bubble_read_data", data_out[0], 16'h1234);
        last_rd[0] = 16'h1234;

        // Three wait states; addr moved to another written word during WAIT.
        mem_op(1, 1'b1, 16'h3000, 16'hCAFE);
        mem_op(1, 1'b1, 16'h3005, 16'h1111);
        do_access(1, 1'b0, 16'h3000, 16'h0000, 16'h3005, rd, ack, dv, dd);
        check("wait3_addr_change_ignored", rd, 16'hCAFE);
        last_rd[1] = 16'hCAFE;

        // Random traffic on controllers 0 and 1 against the model.
        for (int i = 0; i < 6; i++) begin
            pool[i] = 16'h5000 + 16'(i);
        end
        pool[0] = 16'h0000;
        pool[5] = 16'hFFFF;
        for (int i = 0; i < 40; i++) begin
            int          d;
            logic [15:0] a;
            bit          wr;
            d  = i % 2;
            a  = pool[$urandom_range(0, 5)];
            wr = 1'($urandom) || !ref_mem.exists(key(d, a));
            mem_op(d, wr, a, 16'($urandom));
        end

        // Reset during WAIT of a write must abort it.
        mem_op(2, 1'b1, 16'h4000, 16'h5555);
        mem_op(2, 1'b0, 16'h4000, 16'h0000);
        mio_en[2]  = 1'b1;
        rw[2]      = 1'b1;
        addr[2]    = 16'h4000;
        data_in[2] = 16'hAAAA;
        r_seen     = 0;
        @(posedge clk);
        #1;
        mio_en[2] = 1'b0;
        for (int n = 0; n < 2; n++) begin
            @(posedge clk);
            #1;
            if (r[2]) r_seen++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_mid_data_out", data_out[2], 16'h0);
        check("reset_mid_r", r[2], 1'b0);
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            if (r[2]) r_seen++;
        end
        check("no_r_for_aborted_write", r_seen, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int d = 0; d < ND; d++) last_rd[d] = 16'h0;
        mem_op(2, 1'b0, 16'h4000, 16'h0000);

`ifdef LC3_MMIO_EN
        @(negedge clk);
        kbd_valid = 1'b1;
        kbd_data  = 8'h41;
        @(negedge clk);
        kbd_valid = 1'b0;
        kbd_data  = 8'h00;
        run(0, 1'b0, 16'hFE00, 16'h0, 16'h8000, ack, dv, dd);
        run(0, 1'b0, 16'hFE02, 16'h0, 16'h0041, ack, dv, dd);
        check("kbd_ack_with_r", ack, 1'b1);
        run(0, 1'b0, 16'hFE00, 16'h0, 16'h0000, ack, dv, dd);
        run(0, 1'b1, 16'hFE06, 16'h0058, 16'h0, ack, dv, dd);
        check("dsp_valid_with_r", dv, 1'b1);
        check("dsp_data", dd, 8'h58);
        dsp_ready = 1'b1;
        run(0, 1'b0, 16'hFE04, 16'h0, 16'h8000, ack, dv, dd);
        dsp_ready = 1'b0;
        run(0, 1'b0, 16'hFE04, 16'h0, 16'h0000, ack, dv, dd);
`else
        // Device addresses are ordinary memory; device outputs stay 0.
        kbd_valid = 1'b1;
        kbd_data  = 8'h41;
        dsp_ready = 1'b1;
        run(0, 1'b1, 16'hFE06, 16'h0058, 16'h0, ack, dv, dd);
        check("no_dsp_without_mmio", {dv, dd}, 9'h0);
        ref_mem[key(0, 16'hFE06)] = 16'h0058;
        run(0, 1'b0, 16'hFE06, 16'h0, 16'h0058, ack, dv, dd);
        check("no_kbd_ack_without_mmio", ack, 1'b0);
        kbd_valid = 1'b0;
        dsp_ready = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
